// File: rtl/prbs_param_checker.sv
// prbs_param_checker: self-synchronising PRBS word checker.
// Keeps the last ORDER received bits and predicts each new bit from received bits only
// (b[t] = b[t-N] ^ b[t-N+TAP]), so any word width works and no seed is needed.
// Flow: FILL (prime history) -> SEARCH (wait for LOCK_WORDS clean words) -> LOCKED
// (count bit errors / checked words; UNLOCK_WORDS consecutive bad words drop lock).
// Ports:
//   clk, reset         word clock, synchronous active-high reset
//   enable             0 holds the checker in FILL; counters are kept
//   clear_cnt          synchronous clear of err_count / word_count (wins over updates)
//   din_valid, din     received word; bit 0 is earliest in time
//   locked             checker locked to the stream
//   err_bits, err_flag per-bit mismatch of the last checked word, and its OR
//   lost_lock          1-cycle pulse on LOCKED -> SEARCH
//   err_count          saturating bit-error count (LOCKED words only)
//   word_count         saturating checked-word count (LOCKED words only)
module prbs_param_checker #(
  parameter int unsigned WORDWIDTH    = 16,
  parameter int unsigned ORDER        = 17,
  parameter int unsigned TAP          = 3,
  parameter int unsigned LOCK_WORDS   = 4,
  parameter int unsigned UNLOCK_WORDS = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear_cnt,
  input  logic                 din_valid,
  input  logic [WORDWIDTH-1:0] din,
  output logic                 locked,
  output logic [WORDWIDTH-1:0] err_bits,
  output logic                 err_flag,
  output logic                 lost_lock,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     word_count
);

  localparam int unsigned CatW      = ORDER + WORDWIDTH;
  localparam int unsigned FillWords = (ORDER + WORDWIDTH - 1) / WORDWIDTH;
  localparam int unsigned FillW     = $clog2(FillWords + 1);
  localparam int unsigned LockW     = $clog2(LOCK_WORDS + 1);
  localparam int unsigned UnlockW   = $clog2(UNLOCK_WORDS + 1);
  localparam int unsigned PopW      = $clog2(WORDWIDTH + 1);

  typedef enum logic [1:0] {StFill, StSearch, StLocked} state_e;

  state_e               state_q, state_d;
  logic [ORDER-1:0]     hist_q, hist_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic [LockW-1:0]     clean_q, clean_d;
  logic [UnlockW-1:0]   bad_q, bad_d;
  logic [WORDWIDTH-1:0] err_bits_q, err_bits_d;
  logic                 err_flag_q, err_flag_d;
  logic                 lost_q, lost_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;

  logic                 accept;
  logic [CatW-1:0]      cat;
  logic [WORDWIDTH-1:0] err_raw;
  logic [PopW-1:0]      err_pop;
  logic                 zero_word;
  logic                 word_bad;
  logic [CNT_W:0]       err_sum;
  logic [CNT_W:0]       word_sum;

  // Mismatch of every new bit against its prediction from the received window.
  always_comb begin
    accept  = enable & din_valid;
    cat     = {din, hist_q};
    err_raw = '0;
    err_pop = '0;
    for (int unsigned j = 0; j < WORDWIDTH; j++) begin
      err_raw[j] = cat[ORDER+j] ^ cat[j] ^ cat[j+TAP];
      err_pop    = err_pop + PopW'(err_raw[j]);
    end
    // An all-zero window satisfies the recurrence trivially; never treat it as clean.
    zero_word = ~|cat;
    word_bad  = (|err_raw) | zero_word;
    err_sum   = {1'b0, err_cnt_q} + (CNT_W+1)'(err_pop);
    word_sum  = {1'b0, word_cnt_q} + (CNT_W+1)'(1);
  end

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    clean_d    = clean_q;
    bad_d      = bad_q;
    err_bits_d = '0;
    err_flag_d = 1'b0;
    lost_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;

    if (!enable) begin
      state_d = StFill;
      fill_d  = '0;
      clean_d = '0;
      bad_d   = '0;
    end else if (accept) begin
      hist_d = cat[CatW-1 -: ORDER];
      unique case (state_q)
        StFill: begin
          // Filling words only prime the history; they are not checked.
          if (fill_q == FillW'(FillWords - 1)) begin
            state_d = StSearch;
            fill_d  = '0;
            clean_d = '0;
          end else begin
            fill_d = fill_q + FillW'(1);
          end
        end
        StSearch: begin
          err_bits_d = err_raw;
          err_flag_d = |err_raw;
          if (word_bad) begin
            clean_d = '0;
          end else if (clean_q == LockW'(LOCK_WORDS - 1)) begin
            state_d = StLocked;
            clean_d = '0;
            bad_d   = '0;
          end else begin
            clean_d = clean_q + LockW'(1);
          end
        end
        StLocked: begin
          err_bits_d = err_raw;
          err_flag_d = |err_raw;
          err_cnt_d  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
          word_cnt_d = word_sum[CNT_W] ? '1 : word_sum[CNT_W-1:0];
          if (!word_bad) begin
            bad_d = '0;
          end else if (bad_q == UnlockW'(UNLOCK_WORDS - 1)) begin
            // History is kept: the stream is usually still close to valid.
            state_d = StSearch;
            lost_d  = 1'b1;
            clean_d = '0;
            bad_d   = '0;
          end else begin
            bad_d = bad_q + UnlockW'(1);
          end
        end
        default: begin
          state_d = StFill;
          fill_d  = '0;
        end
      endcase
    end

    if (clear_cnt) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFill;
      hist_q     <= '0;
      fill_q     <= '0;
      clean_q    <= '0;
      bad_q      <= '0;
      err_bits_q <= '0;
      err_flag_q <= 1'b0;
      lost_q     <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      clean_q    <= clean_d;
      bad_q      <= bad_d;
      err_bits_q <= err_bits_d;
      err_flag_q <= err_flag_d;
      lost_q     <= lost_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign locked     = (state_q == StLocked);
  assign err_bits   = err_bits_q;
  assign err_flag   = err_flag_q;
  assign lost_lock  = lost_q;
  assign err_count  = err_cnt_q;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_prbs_param_checker.sv
// Bench for prbs_param_checker (W=16, PRBS17, 8-bit counters so saturation is reachable).
module tb_prbs_param_checker;

  localparam int CW  = 8;
  localparam int MAX = 255;

  logic          clk = 1'b0;
  logic          reset, enable, clear_cnt, din_valid;
  logic [15:0]   din;
  logic          locked, err_flag, lost_lock;
  logic [15:0]   err_bits;
  logic [CW-1:0] err_count, word_count;

  prbs_param_checker #(
    .WORDWIDTH   (16),
    .ORDER       (17),
    .TAP         (3),
    .LOCK_WORDS  (4),
    .UNLOCK_WORDS(4),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clear_cnt (clear_cnt),
    .din_valid (din_valid),
    .din       (din),
    .locked    (locked),
    .err_bits  (err_bits),
    .err_flag  (err_flag),
    .lost_lock (lost_lock),
    .err_count (err_count),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        locked;
    logic [15:0] err_bits;
    logic        err_flag;
    logic        lost;
    int          ec;
    int          wc;
  } exp_t;

  typedef struct {
    logic val;
    logic exp_locked;
    int   exp_wc;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // PRBS17 source: gq holds b[t-17..t-1], oldest first.
  bit gq[$];
  // Reference model state: rx holds every received bit since reset (17 zeros of history first).
  bit rx[$];
  int m_st, m_fill, m_clean, m_bad, m_ec, m_wc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic gen_word(output logic [15:0] w);
    bit nb;
    for (int j = 0; j < 16; j++) begin
      nb = gq[0] ^ gq[3];
      gq.push_back(nb);
      gq = gq[1:$];
      w[j] = nb;
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAX) ? MAX : v;
  endfunction

  task automatic model(input logic e, input logic v, input logic c, input logic r,
                       input logic [15:0] d, output exp_t x);
    logic [15:0] err;
    bit          zero;
    bit          wbad;
    int          t;
    x.err_bits = '0;
    x.err_flag = 1'b0;
    x.lost     = 1'b0;
    if (r) begin
      rx = {};
      for (int i = 0; i < 17; i++) rx.push_back(1'b0);
      m_st = 0; m_fill = 0; m_clean = 0; m_bad = 0; m_ec = 0; m_wc = 0;
    end else begin
      if (!e) begin
        m_st = 0; m_fill = 0; m_clean = 0; m_bad = 0;
      end else if (v) begin
        for (int j = 0; j < 16; j++) begin
          rx.push_back(d[j]);
          t = rx.size() - 1;
          err[j] = rx[t] ^ rx[t-17] ^ rx[t-14];
        end
        zero = 1'b1;
        for (int k = 0; k < 33; k++) if (rx[rx.size()-1-k]) zero = 1'b0;
        wbad = (err != 0) || zero;
        case (m_st)
          0: begin
            m_fill++;
            if (m_fill == 2) begin m_st = 1; m_fill = 0; m_clean = 0; end
          end
          1: begin
            x.err_bits = err;
            x.err_flag = (err != 0);
            if (wbad) m_clean = 0;
            else begin
              m_clean++;
              if (m_clean == 4) begin m_st = 2; m_clean = 0; m_bad = 0; end
            end
          end
          default: begin
            x.err_bits = err;
            x.err_flag = (err != 0);
            m_wc = sat(m_wc + 1);
            m_ec = sat(m_ec + $countones(err));
            if (wbad) begin
              m_bad++;
              if (m_bad == 4) begin m_st = 1; x.lost = 1'b1; m_clean = 0; m_bad = 0; end
            end else m_bad = 0;
          end
        endcase
      end
      if (c) begin m_ec = 0; m_wc = 0; end
    end
    x.locked = (m_st == 2);
    x.ec     = m_ec;
    x.wc     = m_wc;
  endtask

  // One clock: drive, predict, push; after the edge pop and compare everything.
  task automatic step(input logic e, input logic v, input logic c, input logic r,
                      input logic [15:0] d);
    exp_t x;
    enable = e; din_valid = v; clear_cnt = c; reset = r; din = d;
    model(e, v, c, r, d, x);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("sb_locked", 32'(locked), 32'(x.locked));
    check("sb_err_bits", 32'(err_bits), 32'(x.err_bits));
    check("sb_err_flag", 32'(err_flag), 32'(x.err_flag));
    check("sb_lost_lock", 32'(lost_lock), 32'(x.lost));
    check("sb_err_count", 32'(err_count), 32'(x.ec));
    check("sb_word_count", 32'(word_count), 32'(x.wc));
  endtask

  // Next PRBS word with an optional XOR mask applied on the line.
  task automatic word(input logic [15:0] mask);
    logic [15:0] w;
    gen_word(w);
    step(1'b1, 1'b1, 1'b0, 1'b0, w ^ mask);
  endtask

  vec_t tbl[11];

  initial begin
    logic [15:0] w;
    int          ec0, wc0;
    bit          got;
    logic [16:0] seed;

    seed = 17'h1ACE5;
    for (int i = 0; i < 17; i++) gq.push_back(seed[i]);
    enable = 1'b0; din_valid = 1'b0; clear_cnt = 1'b0; reset = 1'b1; din = '0;

    // Test 1: lock after 2 fill + 4 clean words; gaps don't count.
    tbl[0]  = '{1'b1, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b1, 0};
    tbl[6]  = '{1'b0, 1'b1, 0};
    tbl[7]  = '{1'b1, 1'b1, 1};
    tbl[8]  = '{1'b1, 1'b1, 2};
    tbl[9]  = '{1'b0, 1'b1, 2};
    tbl[10] = '{1'b1, 1'b1, 3};

    // Reset wins over a valid word.
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].val) gen_word(w);
      else w = 16'($urandom);
      step(1'b1, tbl[i].val, 1'b0, 1'b0, w);
      check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].exp_locked));
      check($sformatf("tbl%0d_wc", i), 32'(word_count), 32'(tbl[i].exp_wc));
      check($sformatf("tbl%0d_ec", i), 32'(err_count), 32'd0);
    end

    // Test 2: single flipped line bit -> 3 errors over two words.
    ec0 = int'(err_count);
    word(16'h0001);
    check("flip_bits0", 32'(err_bits), 32'h4001);
    check("flip_flag0", 32'(err_flag), 32'd1);
    word(16'h0000);
    check("flip_bits1", 32'(err_bits), 32'h0002);
    check("flip_flag1", 32'(err_flag), 32'd1);
    word(16'h0000);
    check("flip_flag2", 32'(err_flag), 32'd0);
    check("flip_cnt", 32'(err_count), 32'(ec0 + 3));
    check("flip_locked", 32'(locked), 32'd1);

    // Test 4: inverted stream -> unlock on 4th word; 14+15+16+16 bit errors.
    ec0 = int'(err_count);
    wc0 = int'(word_count);
    word(16'hFFFF);
    check("inv_bits0", 32'(err_bits), 32'h3FFF);
    word(16'hFFFF);
    check("inv_bits1", 32'(err_bits), 32'hFFFE);
    word(16'hFFFF);
    check("inv_locked3", 32'(locked), 32'd1);
    word(16'hFFFF);
    check("inv_bits3", 32'(err_bits), 32'hFFFF);
    check("inv_unlocked", 32'(locked), 32'd0);
    check("inv_lost", 32'(lost_lock), 32'd1);
    check("inv_ec", 32'(err_count), 32'(ec0 + 61));
    check("inv_wc", 32'(word_count), 32'(wc0 + 4));
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      word(16'h0000);
      if (i == 0) check("inv_lost_pulse", 32'(lost_lock), 32'd0);
      if (locked) got = 1'b1;
    end
    check("relock_6", 32'(got), 32'd1);

    // Test 5: valid gaps ignored; enable pulse forces FILL, counters retained.
    wc0 = int'(word_count);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
    word(16'h0000);
    check("gap_locked", 32'(locked), 32'd1);
    check("gap_wc", 32'(word_count), 32'(wc0 + 1));
    ec0 = int'(err_count);
    wc0 = int'(word_count);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'($urandom));
    check("en_locked", 32'(locked), 32'd0);
    check("en_ec_kept", 32'(err_count), 32'(ec0));
    check("en_wc_kept", 32'(word_count), 32'(wc0));
    for (int i = 0; i < 5; i++) word(16'h0000);
    check("en_relock5", 32'(locked), 32'd0);
    word(16'h0000);
    check("en_relock6", 32'(locked), 32'd1);

    // Test 6: clear_cnt beats a counted word.
    gen_word(w);
    step(1'b1, 1'b1, 1'b1, 1'b0, w);
    check("clr_ec", 32'(err_count), 32'd0);
    check("clr_wc", 32'(word_count), 32'd0);
    check("clr_locked", 32'(locked), 32'd1);

    // Saturation: a flip every third word never drops lock.
    for (int i = 0; i < 300; i++) word((i % 3 == 0) ? 16'h0001 : 16'h0000);
    check("sat_locked", 32'(locked), 32'd1);
    check("sat_ec", 32'(err_count), 32'(MAX));
    check("sat_wc", 32'(word_count), 32'(MAX));

    // Reset while locked, then relock from scratch.
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'($urandom));
    check("rst2_locked", 32'(locked), 32'd0);
    check("rst2_bits", 32'(err_bits), 32'd0);
    check("rst2_ec", 32'(err_count), 32'd0);
    check("rst2_wc", 32'(word_count), 32'd0);
    for (int i = 0; i < 5; i++) word(16'h0000);
    check("rst2_relock5", 32'(locked), 32'd0);
    word(16'h0000);
    check("rst2_relock6", 32'(locked), 32'd1);

    // Test 3: all-zero words never lock.
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      if (locked || err_flag) got = 1'b1;
    end
    check("zero_never_lock", 32'(got), 32'd0);
    check("zero_ec", 32'(err_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
